// File: rtl/password_pkg.sv
// Shared types and constants for the password issuer.
// ISSUER_FIXED_PW_EN selects the FIXED_PW table over the LFSR.
package password_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    OFFER,
    PLAY,
    WIN,
    FAIL
  } state_e;

  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;
  localparam logic [LFSR_W-1:0] DEF_SEED = 10'h2A5;

  localparam int MIN_TIME  = 10;
  localparam int TIME_STEP = 5;

  localparam logic [LFSR_W-1:0] FIXED_PW [9] = '{
    10'h15A, 10'h0C3, 10'h2E7, 10'h391, 10'h04F,
    10'h1B6, 10'h26D, 10'h3F2, 10'h0A8
  };

  // x^10 + x^7 + 1, shifting toward the MSB
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] v
  );
    return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR with synchronous load and step enable.
// Load has priority over step.
module lfsr10
  import password_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= DEF_SEED;
    end else if (load) begin
      q_q <= load_val;
    end else if (step) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/password_issuer.sv
// Level-based password issuer with valid/ready offer handshake.
// Define ISSUER_FIXED_PW_EN to issue passwords from FIXED_PW.
module password_issuer
  import password_pkg::*;
#(
  parameter int NUM_LEVELS = 5,
  parameter int BASE_TIME  = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [9:0] seed,
  input  logic       solved,
  input  logic       timeout,
  input  logic       pw_ready,
  output logic       pw_valid,
  output logic [9:0] password,
  output logic [3:0] level,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       win,
  output logic       fail
);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  level_q;
  logic [9:0]  pw_q;
  logic        valid_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;
  logic        win_q;
  logic        fail_q;

  logic [9:0]  lfsr_q;
  logic [9:0]  lfsr_seed;
  logic        lfsr_step;
  logic [9:0]  pw_d;
  logic [3:0]  tens_d;
  logic [3:0]  ones_d;
  int          t_c;

  assign lfsr_seed = (seed == '0) ? DEF_SEED : seed;
  assign lfsr_step = (state_q == GEN) && !start;

  lfsr10 u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start),
    .load_val (lfsr_seed),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // Password is captured on the same edge as the final GEN step
`ifdef ISSUER_FIXED_PW_EN
  assign pw_d = FIXED_PW[level_q - 4'd1];
`else
  assign pw_d = lfsr_next(lfsr_q);
`endif

  always_comb begin
    t_c = BASE_TIME - TIME_STEP * (int'(level_q) - 1);
    if (t_c < MIN_TIME) t_c = MIN_TIME;
    tens_d = 4'(t_c / 10);
    ones_d = 4'(t_c % 10);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= '0;
      pw_q    <= '0;
      valid_q <= 1'b0;
      tens_q  <= '0;
      ones_q  <= '0;
      win_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else if (start) begin
      state_q <= GEN;
      cnt_q   <= '0;
      level_q <= 4'd1;
      valid_q <= 1'b0;
      win_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      unique case (state_q)
        GEN: begin
          if (cnt_q == level_q) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            pw_q    <= pw_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        OFFER: begin
          if (pw_ready) begin
            state_q <= PLAY;
            valid_q <= 1'b0;
          end
        end
        PLAY: begin
          if (solved) begin
            if (level_q == 4'(NUM_LEVELS)) begin
              state_q <= WIN;
              win_q   <= 1'b1;
            end else begin
              state_q <= GEN;
              level_q <= level_q + 4'd1;
              cnt_q   <= '0;
            end
          end else if (timeout) begin
            state_q <= FAIL;
            fail_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pw_valid  = valid_q;
  assign password  = pw_q;
  assign level     = level_q;
  assign time_tens = tens_q;
  assign time_ones = ones_q;
  assign win       = win_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_password_issuer.sv
// Scoreboard bench for password_issuer (3 levels, 30 s base).
// Expected offers are queued at start/solved and popped on pw_valid.
module tb_password_issuer;

  typedef struct {
    logic [9:0] pw;
    logic [3:0] lvl;
    logic [3:0] tens;
    logic [3:0] ones;
  } offer_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] seed;
  logic       solved;
  logic       timeout;
  logic       pw_ready;
  logic       pw_valid;
  logic [9:0] password;
  logic [3:0] level;
  logic [3:0] time_tens;
  logic [3:0] time_ones;
  logic       win;
  logic       fail;

  int n_chk  = 0;
  int n_pass = 0;

  offer_t     exp_q[$];
  logic [9:0] m_lfsr;
  int         m_lvl;
  logic [9:0] pw_log[$];
  logic [9:0] held;

  password_issuer #(
    .NUM_LEVELS (3),
    .BASE_TIME  (30)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .seed      (seed),
    .solved    (solved),
    .timeout   (timeout),
    .pw_ready  (pw_ready),
    .pw_valid  (pw_valid),
    .password  (password),
    .level     (level),
    .time_tens (time_tens),
    .time_ones (time_ones),
    .win       (win),
    .fail      (fail)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] m_step(input logic [9:0] v);
    logic fb;
    fb = v[9] ^ v[6];
    return {v[8:0], fb};
  endfunction

  task automatic push_exp();
    offer_t o;
    int t;
    for (int i = 0; i < m_lvl + 1; i++) m_lfsr = m_step(m_lfsr);
    t = 30 - 5 * (m_lvl - 1);
    if (t < 10) t = 10;
    o.pw   = m_lfsr;
    o.lvl  = 4'(m_lvl);
    o.tens = 4'(t / 10);
    o.ones = 4'(t % 10);
    exp_q.push_back(o);
  endtask

  task automatic do_start(input logic [9:0] s);
    seed   = s;
    m_lfsr = (s == 10'd0) ? 10'h2A5 : s;
    m_lvl  = 1;
    push_exp();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_solve(input logic also_to);
    m_lvl++;
    push_exp();
    solved  = 1'b1;
    timeout = also_to;
    @(negedge clk);
    solved  = 1'b0;
    timeout = 1'b0;
  endtask

  task automatic expect_offer(input string tag);
    offer_t o;
    int n;
    n = 0;
    while (!pw_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_qnz"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      o = exp_q.pop_front();
      check_eq({tag, "_lat"}, n, o.lvl + 1);
      check_eq({tag, "_pw"}, password, o.pw);
      check_eq({tag, "_lvl"}, level, o.lvl);
      check_eq({tag, "_time"}, {time_tens, time_ones},
               {o.tens, o.ones});
      pw_log.push_back(password);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    seed     = '0;
    solved   = 1'b0;
    timeout  = 1'b0;
    pw_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_outs",
             {password, pw_valid, level, time_tens, time_ones, win, fail},
             0);
    reset_n = 1'b1;

    solved  = 1'b1;
    timeout = 1'b1;
    @(negedge clk);
    solved  = 1'b0;
    timeout = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_valid", pw_valid, 0);
    check_eq("idle_lvl", level, 0);
    check_eq("idle_fail", fail, 0);

    do_start(10'h001);
    expect_offer("l1");
    @(negedge clk);
    check_eq("l1_drop", pw_valid, 0);

    pw_ready = 1'b0;
    do_solve(1'b0);
    expect_offer("l2");
    held = password;
    for (int i = 0; i < 20; i++) begin
      solved  = i[0];
      timeout = ~i[0];
      @(negedge clk);
      check_eq("hold", {pw_valid, password, level}, {1'b1, held, 4'd2});
    end
    solved   = 1'b0;
    timeout  = 1'b0;
    pw_ready = 1'b1;
    @(negedge clk);
    check_eq("l2_drop", pw_valid, 0);

    do_solve(1'b1);
    check_eq("both_lvl", level, 3);
    check_eq("both_fail", fail, 0);
    expect_offer("l3");
    @(negedge clk);
    check_eq("l3_drop", pw_valid, 0);

    for (int i = 0; i < pw_log.size(); i++) begin
      check_eq("pw_nz", 32'(pw_log[i] != 10'd0), 1);
      if (i > 0)
        check_eq("pw_diff", 32'(pw_log[i] != pw_log[i-1]), 1);
    end

    solved = 1'b1;
    @(negedge clk);
    solved = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("win", {win, level, pw_valid}, {1'b1, 4'd3, 1'b0});

    do_start(10'd0);
    check_eq("rst_win", {win, level}, {1'b0, 4'd1});
    expect_offer("s0");
    @(negedge clk);
    timeout = 1'b1;
    @(negedge clk);
    timeout = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("fail", {fail, level}, {1'b1, 4'd1});
    solved = 1'b1;
    @(negedge clk);
    solved = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("fail_hold", {fail, level, pw_valid}, {1'b1, 4'd1, 1'b0});

    do_start(10'd0);
    check_eq("clr_fail", {fail, level}, {1'b0, 4'd1});
    expect_offer("s0b");
    @(negedge clk);

    pw_ready = 1'b0;
    do_start(10'h155);
    expect_offer("pre_rst");
    #2 reset_n = 1'b0;
    #1 check_eq("async_rst",
                {password, pw_valid, level, time_tens, time_ones, win, fail},
                0);
    @(negedge clk);
    reset_n  = 1'b1;
    pw_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post_rst", {pw_valid, level}, 0);
    check_eq("q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
